// File: rtl/seq_div16.sv
// seq_div16 -- multi-cycle unsigned divider (restoring shift-subtract).
//
// Computes q = a / b and r = a % b, producing one quotient bit per clock. The
// trial subtract is a WIDTH-bit carry-lookahead subtractor made of 4-bit P/G
// groups. The subtrahend b is inverted and the carry-in is 1.
//
// Handshake: start is sampled only while busy=0, that is in IDLE or DONE.
// The accepting edge latches a and b. busy stays high until the edge that
// publishes the result. That same edge raises done for exactly one cycle.
// q, r and dbz hold their values until the next result is published.
//
// Ports
//   clk        in   1      rising-edge clock
//   nrst       in   1      asynchronous active-low reset
//   start      in   1      request a division (ignored while busy)
//   a          in   WIDTH  dividend
//   b          in   WIDTH  divisor
//   busy       out  1      division in progress
//   done       out  1      one-cycle pulse: q/r/dbz just updated
//   q          out  WIDTH  quotient
//   r          out  WIDTH  remainder
//   dbz        out  1      divide-by-zero flag of the current result
//   dbg_state  out  2      FSM state (0 IDLE, 1 RUN, 2 DONE)
module seq_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int NGRP  = WIDTH / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [WIDTH-1:0]  rem, dq;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              last;
    logic              b_zero;

    // Trial subtract datapath.
    logic              t_hi;         // bit WIDTH of the shifted partial remainder
    logic [WIDTH-1:0]  t_lo;         // low WIDTH bits of the shifted partial remainder
    logic [WIDTH-1:0]  y_inv;        // ~b
    logic [WIDTH-1:0]  pv, gv;       // per-bit propagate / generate
    logic [WIDTH:0]    c;            // carries, c[0] is the carry-in
    logic [WIDTH-1:0]  s;            // t_lo - b (mod 2^WIDTH)
    logic [NGRP-1:0]   grp_p, grp_g;
    logic              no_borrow;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  dq_next;

    assign accept = start && (state != RUN);
    assign b_zero = (b_reg == '0);
    // A zero divisor spends exactly one RUN cycle and then publishes the
    // fixed divide-by-zero result.
    assign last   = b_zero || (count == CNT_W'(WIDTH - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        dbg_state = state;
    end

    // ---------------- Carry-lookahead subtractor ----------------
    // The shifted partial remainder t is WIDTH+1 bits wide. Only its low
    // WIDTH bits go through the adder. The subtraction t - b does not borrow
    // when t's top bit is set or when the low part produces a carry-out.
    assign t_hi  = rem[WIDTH-1];
    assign t_lo  = {rem[WIDTH-2:0], dq[WIDTH-1]};
    assign y_inv = ~b_reg;
    assign pv    = t_lo ^ y_inv;
    assign gv    = t_lo & y_inv;

    always_comb begin
        c     = '0;
        c[0]  = 1'b1;
        grp_p = '0;
        grp_g = '0;
        for (int grp = 0; grp < NGRP; grp++) begin
            // Inside a group, every carry is expressed from the group carry-in.
            c[grp*4+1] = gv[grp*4] | (pv[grp*4] & c[grp*4]);
            c[grp*4+2] = gv[grp*4+1] | (pv[grp*4+1] & gv[grp*4])
                       | (pv[grp*4+1] & pv[grp*4] & c[grp*4]);
            c[grp*4+3] = gv[grp*4+2] | (pv[grp*4+2] & gv[grp*4+1])
                       | (pv[grp*4+2] & pv[grp*4+1] & gv[grp*4])
                       | (pv[grp*4+2] & pv[grp*4+1] & pv[grp*4] & c[grp*4]);
            grp_p[grp] = &pv[grp*4 +: 4];
            grp_g[grp] = gv[grp*4+3] | (pv[grp*4+3] & gv[grp*4+2])
                       | (pv[grp*4+3] & pv[grp*4+2] & gv[grp*4+1])
                       | (pv[grp*4+3] & pv[grp*4+2] & pv[grp*4+1] & gv[grp*4]);
            c[grp*4+4] = grp_g[grp] | (grp_p[grp] & c[grp*4]);
        end
        s = pv ^ c[WIDTH-1:0];
    end

    assign no_borrow = t_hi | c[WIDTH];
    assign rem_next  = no_borrow ? s : t_lo;
    assign dq_next   = {dq[WIDTH-2:0], no_borrow};

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            a_reg <= '0;
            b_reg <= '0;
            rem   <= '0;
            dq    <= '0;
            count <= '0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            rem   <= '0;
            dq    <= a;
            count <= '0;
        end else if (state == RUN) begin
            rem   <= rem_next;
            dq    <= dq_next;
            count <= count + 1'b1;
            if (last) begin
                if (b_zero) begin
                    q   <= '1;
                    r   <= a_reg;
                    dbz <= 1'b1;
                end else begin
                    q   <= dq_next;
                    r   <= rem_next;
                    dbz <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div16.sv
module tb_seq_div16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, dbz;
    logic [W-1:0] q, r;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    seq_div16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .a         (a_in),
        .b         (b_in),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .dbz       (dbz),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] qe, output logic [W-1:0] re,
                                  output logic ze);
        if (bv == 0) begin
            qe = {W{1'b1}};
            re = av;
            ze = 1'b1;
        end else begin
            qe = av / bv;
            re = av % bv;
            ze = 1'b0;
        end
    endfunction

    // ---------------- drivers ----------------
    // Present one start pulse. Returns #1 after the accepting edge.
    task automatic start_div(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen. The wait is bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst  = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, dbz} !== 3'b000 || q !== '0 || r !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, dbz, q, r);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // One division checked against the model, including its latency.
    task automatic run_and_check(input string name, input logic [W-1:0] av,
                                 input logic [W-1:0] bv);
        int edges, exp_lat;
        logic [W-1:0] qe, re;
        logic ze;
        model(av, bv, qe, re, ze);
        exp_lat = (bv == 0) ? 1 : W;
        start_div(av, bv);
        wait_done(edges);
        checks++;
        if (edges !== exp_lat || q !== qe || r !== re || dbz !== ze || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s a=%h b=%h: lat=%0d q=%h r=%h dbz=%b busy=%b, want lat=%0d q=%h r=%h dbz=%b busy=0",
                     name, av, bv, edges, q, r, dbz, busy, exp_lat, qe, re, ze);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] q_hold;
        run_and_check("basic_100_7", 16'd100, 16'd7);
        checks++;
        if (q !== 16'd14 || r !== 16'd2) begin
            errors++;
            $display("FAIL basic_const: q=%0d r=%0d, want q=14 r=2", q, r);
        end
        q_hold = 16'd14;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || q !== q_hold || r !== 16'd2) begin
            errors++;
            $display("FAIL done_pulse: done=%b q=%0d r=%0d, want done=0 q=14 r=2", done, q, r);
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] ta [6] = '{16'hFFFF, 16'hFFFF, 16'd3,  16'd0, 16'd7, 16'h8000};
        logic [W-1:0] tb [6] = '{16'd1,    16'hFFFF, 16'd10, 16'd5, 16'd7, 16'h7FFF};
        for (int i = 0; i < 6; i++) run_and_check("boundary", ta[i], tb[i]);
    endtask

    task automatic test_div_zero();
        run_and_check("div_zero", 16'd5, 16'd0);
        checks++;
        if (q !== 16'hFFFF || r !== 16'd5 || dbz !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_const: q=%h r=%0d dbz=%b, want q=ffff r=5 dbz=1", q, r, dbz);
        end
        run_and_check("after_dbz", 16'd9, 16'd3);
    endtask

    task automatic test_ignore_start();
        int edges;
        start_div(16'd100, 16'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        a_in  = 16'd1;
        b_in  = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        checks++;
        if (edges + 6 !== 16 || q !== 16'd14 || r !== 16'd2 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: lat=%0d q=%0d r=%0d dbz=%b, want lat=16 q=14 r=2 dbz=0",
                     edges + 6, q, r, dbz);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        int edges;
        start_div(16'd200, 16'd9);
        repeat (8) @(posedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        checks++;
        if ({busy, done, dbz} !== 3'b000 || q !== '0 || r !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
                     busy, done, dbz, q, r);
        end
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        // Release reset together with start; the first edge with nrst=1 accepts it.
        @(negedge clk);
        nrst  = 1'b1;
        a_in  = 16'd40;
        b_in  = 16'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        checks++;
        if (seen_done != 0 || edges !== 16 || q !== 16'd6 || r !== 16'd4) begin
            errors++;
            $display("FAIL reset_release: done_during_reset=%0d lat=%0d q=%0d r=%0d, want 0 16 6 4",
                     seen_done, edges, q, r);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        run_and_check("b2b_first", 16'd1000, 16'd33);
        // We are inside the DONE cycle: issue the next start right away.
        a_in  = 16'd40;
        b_in  = 16'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        wait_done(edges);
        checks++;
        if (edges !== 16 || q !== 16'd6 || r !== 16'd4 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d q=%0d r=%0d dbz=%b, want 16 6 4 0", edges, q, r, dbz);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv;
        for (int i = 0; i < 40; i++) begin
            av = W'($urandom);
            case ($urandom_range(0, 3))
                0: bv = '0;
                1: bv = W'($urandom_range(1, 15));
                2: bv = W'($urandom_range(1, 300));
                default: bv = W'($urandom);
            endcase
            run_and_check("random", av, bv);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
